// File: rtl/proc_pkg.sv
// Shared opcodes and context-switch FSM state encoding.
// Optional feature macro used by this slice: CSU_STATS_EN (switch counter).
package proc_pkg;

   localparam logic [5:0] OP_CTXSW = 6'b111111;
   localparam logic [5:0] OP_NOP   = 6'b101000;
   localparam logic [5:0] OP_ADDPC = 6'b000110;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAVE   = 2'd1,
      SETTLE = 2'd2,
      COMMIT = 2'd3
   } csu_state_t;

   // Major opcode field of a decoded instruction word.
   function automatic logic [5:0] opcode_of(input logic [31:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/context_pc_table.sv
// Saved-PC table: one entry per context plus a valid bit.
// One synchronous write port, one combinational read port, valid bits cleared on reset.
module context_pc_table #(
   parameter int unsigned NUM_CTX = 8,
   parameter int unsigned IDX_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [31:0]       wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [31:0]       rd_data,
   output logic              rd_valid
);

   logic [31:0]        mem [NUM_CTX];
   logic [NUM_CTX-1:0] vld;

   // Valid bits: cleared by reset, set on every write.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else if (wr_en) begin
         vld[wr_idx] <= 1'b1;
      end
   end

   // Data storage; contents are meaningless until the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data  = mem[rd_idx];
   assign rd_valid = vld[rd_idx];

endmodule

// File: rtl/context_switch_unit.sv
// Context-switch unit: saves the outgoing PC, waits for the pipeline to drain,
// then commits the new context and reloads the PC.
// Optional macro CSU_STATS_EN adds the num_trocas committed-switch counter.
module context_switch_unit
   import proc_pkg::*;
#(
   parameter int unsigned NUM_CTX       = 8,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   input  logic [31:0]      instrucao,
   input  logic [31:0]      reg_a,
   input  logic [31:0]      reg_b,
   input  logic [31:0]      reg_pc_salvo,
   output logic [31:0]      contexto,
   output logic [31:0]      pc_novo,
   output logic             pc_load,
   output logic             ocupado,
   output logic             erro_ctx
`ifdef CSU_STATS_EN
   ,
   output logic [CNT_W-1:0] num_trocas
`endif
);

   localparam int unsigned IDX_W       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
   localparam int unsigned SET_W       = $clog2(SETTLE_CYCLES + 2);
   localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

   csu_state_t         state;
   logic [IDX_W-1:0]   ctx_q;
   logic [IDX_W-1:0]   tgt_q;
   logic [31:0]        br_q;
   logic [31:0]        pcs_q;
   logic [SET_W-1:0]   settle_cnt;

   logic               accept_c;
   logic               tgt_ok_c;
   logic               go_commit_c;
   logic [31:0]        resume_pc_c;
   logic [31:0]        tab_rd_data;
   logic               tab_rd_valid;
   logic               unused_instr_bits;

   assign unused_instr_bits = ^instrucao[25:0];

   // Saved-PC table: written in SAVE with the outgoing context, read with the target.
   context_pc_table #(
      .NUM_CTX (NUM_CTX),
      .IDX_W   (IDX_W)
   ) u_tab (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (state == SAVE),
      .wr_idx   (ctx_q),
      .wr_data  (pcs_q),
      .rd_idx   (tgt_q),
      .rd_data  (tab_rd_data),
      .rd_valid (tab_rd_valid)
   );

   // Opcode decode and target range check (any bit at or above the index width is out of range).
   always_comb begin
      accept_c = instr_valid && (opcode_of(instrucao) == OP_CTXSW) && (state == IDLE);
      tgt_ok_c = (reg_b < 32'(NUM_CTX));
   end

   // Commit point: straight out of SAVE when there is no settle window, else at the last settle cycle.
   always_comb begin
      go_commit_c = ((state == SAVE) && (SETTLE_CYCLES == 32'd0)) ||
                    ((state == SETTLE) && (settle_cnt == SET_W'(SETTLE_LAST)));
   end

   // Resume address; forwards the in-flight save when committing directly from SAVE to the same context.
   always_comb begin
      resume_pc_c = br_q;
      if (tgt_q != '0) begin
         if ((state == SAVE) && (tgt_q == ctx_q)) begin
            resume_pc_c = pcs_q;
         end else if (tab_rd_valid) begin
            resume_pc_c = tab_rd_data;
         end
      end
   end

   // Switch FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ctx_q      <= '0;
         tgt_q      <= '0;
         br_q       <= '0;
         pcs_q      <= '0;
         settle_cnt <= '0;
         pc_novo    <= '0;
         pc_load    <= 1'b0;
         ocupado    <= 1'b0;
         erro_ctx   <= 1'b0;
`ifdef CSU_STATS_EN
         num_trocas <= '0;
`endif
      end else begin
         pc_load  <= 1'b0;
         erro_ctx <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  if (tgt_ok_c) begin
                     tgt_q   <= reg_b[IDX_W-1:0];
                     br_q    <= reg_a;
                     pcs_q   <= reg_pc_salvo;
                     ocupado <= 1'b1;
                     state   <= SAVE;
                  end else begin
                     erro_ctx <= 1'b1;
                  end
               end
            end
            SAVE: begin
               settle_cnt <= '0;
               state      <= SETTLE;
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + SET_W'(1);
            end
            COMMIT: begin
               ocupado <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (go_commit_c) begin
            state   <= COMMIT;
            pc_load <= 1'b1;
            pc_novo <= resume_pc_c;
            ctx_q   <= tgt_q;
`ifdef CSU_STATS_EN
            num_trocas <= num_trocas + CNT_W'(1);
`endif
         end
      end
   end

   assign contexto = 32'(ctx_q);

endmodule
